// File: rtl/ks_subtract_pipe.sv
// ks_subtract_pipe: 3-stage pipelined 8-bit subtractor, a + ~b + 1 through a
// Kogge-Stone parallel-prefix carry network with carry-in tied to 1.
// Valid/ready handshake on both sides; each stage advances independently.
// Optional macro ABS_DIFF_EN: a second prefix network computes b + ~a + 1 and
// diff becomes |a - b|. borrow always means a < b.
module ks_subtract_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       borrow
);

`ifdef ABS_DIFF_EN
    localparam int NNET = 2;
`else
    localparam int NNET = 1;
`endif

    logic       v1_reg, v2_reg, v3_reg;
    logic       load1, load2, load3;
    logic [7:0] diff_reg;
    logic       borrow_reg;
    logic [7:0] diff_next;
    logic [7:0] net_sum  [NNET];
    logic       net_cout [NNET];

    // A stage loads when it is empty or its content leaves in the same cycle.
    always_comb begin
        load3 = ~v3_reg | out_ready;
        load2 = ~v2_reg | load3;
        load1 = ~v1_reg | load2;
    end

    assign in_ready  = rst_n & load1;
    assign out_valid = v3_reg;
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;

    // Stage valid bits; reset drops every in-flight operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            if (load1) v1_reg <= in_valid;
            if (load2) v2_reg <= v1_reg;
            if (load3) v3_reg <= v2_reg;
        end
    end

    // Network 0 computes a - b; network 1 (absolute build only) computes b - a.
    for (genvar gi = 0; gi < NNET; gi++) begin : g_net
        logic [7:0] x, y;
        logic [7:0] s1_g_reg, s1_p_reg;
        logic [7:0] s2_g_reg, s2_h_reg;
        logic [7:4] s2_p_reg;
        logic [7:0] g0, g1, g2, g3;
        logic [7:1] p0;
        logic [7:2] p1;
        logic [7:4] p2;

        assign x = (gi == 0) ? a : b;
        assign y = (gi == 0) ? b : a;

        // Prefix levels 1 and 2 (spans 1 and 2); carry-in folded into bit 0,
        // so group propagates are only kept where a span stops short of bit 0.
        always_comb begin
            g0 = {s1_g_reg[7:1], s1_g_reg[0] | s1_p_reg[0]};
            p0 = s1_p_reg[7:1];
            g1 = g0;
            for (int i = 1; i < 8; i++) g1[i] = g0[i] | (p0[i] & g0[i-1]);
            for (int i = 2; i < 8; i++) p1[i] = p0[i] & p0[i-1];
            g2 = g1;
            for (int i = 2; i < 8; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
            for (int i = 4; i < 8; i++) p2[i] = p1[i] & p1[i-2];
        end

        // Prefix level 3 (span 4): g3[i] is the carry out of bit i.
        always_comb begin
            g3 = s2_g_reg;
            for (int i = 4; i < 8; i++) g3[i] = s2_g_reg[i] | (s2_p_reg[i] & s2_g_reg[i-4]);
        end

        // S1 captures per-bit generate/propagate; S2 captures prefix levels 1-2.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_g_reg <= '0;
                s1_p_reg <= '0;
                s2_g_reg <= '0;
                s2_p_reg <= '0;
                s2_h_reg <= '0;
            end else begin
                if (load1 && in_valid) begin
                    s1_g_reg <= x & ~y;
                    s1_p_reg <= x ^ ~y;
                end
                if (load2 && v1_reg) begin
                    s2_g_reg <= g2;
                    s2_p_reg <= p2;
                    s2_h_reg <= s1_p_reg;
                end
            end
        end

        assign net_sum[gi]  = s2_h_reg ^ {g3[6:0], 1'b1};
        assign net_cout[gi] = g3[7];
    end

    // Output form: wrapped difference, or the non-negative of the two results.
    always_comb begin
`ifdef ABS_DIFF_EN
        diff_next = net_cout[0] ? net_sum[0] : net_sum[1];
`else
        diff_next = net_sum[0];
`endif
    end

    // S3 captures the sum and borrow; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (load3 && v2_reg) begin
            diff_reg   <= diff_next;
            borrow_reg <= ~net_cout[0];
        end
    end

endmodule
